rca_issue_ctrl: RTL

Parametrised issue controller for the reconfigurable custom accelerator (RCA) grid. It sits between the RCA issue interface and the grid IO units. It buffers one RCA-use request and tracks in-flight instruction IDs for in-order writeback. When a request targets a different RCA than the one the grid holds, it drains in-flight work and runs an explicit reconfiguration handshake before issuing. It adds a bounded in-flight tracker, a configured-RCA record and a pipeline flush.

---
 rtl/rca_issue_ctrl_if.sv | 53 +++++
 rtl/rca_issue_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rca_issue_ctrl_if.sv
// Signal bundle between the RCA issue stage (master) and the issue controller (slave).
// Request handshake: a request transfers on a clock edge where req_valid && req_ready.
interface rca_issue_ctrl_if #(
  parameter int XLEN         = 32,
  parameter int NUM_PORTS    = 5,
  parameter int NUM_RCAS     = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int ID_W         = 3
);
  localparam int RCA_W = (NUM_RCAS > 2) ? $clog2(NUM_RCAS) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int RS_W  = NUM_PORTS * XLEN;

  logic             req_valid;
  logic             req_ready;
  logic [ID_W-1:0]  req_id;
  logic [RCA_W-1:0] req_rca;
  logic             req_fb;
  logic [RS_W-1:0]  req_rs;

  logic             issue_valid;
  logic [ID_W-1:0]  issue_id;
  logic [RCA_W-1:0] issue_rca;
  logic             issue_fb;
  logic [RS_W-1:0]  issue_rs;
  logic             clear_fifos;

  logic [RCA_W-1:0] active_rca;
  logic             cfg_req;
  logic [RCA_W-1:0] cfg_rca;
  logic             cfg_done;

  logic             flush;
  logic             wb_commit;
  logic [ID_W-1:0]  wb_id;
  logic             wb_fb;
  logic [CNT_W-1:0] inflight;

  // FSM state, exported for checkers and waveform reading
  logic [1:0]       dbg_state;

  modport master (
    output req_valid, req_id, req_rca, req_fb, req_rs, cfg_done, flush, wb_commit,
    input  req_ready, issue_valid, issue_id, issue_rca, issue_fb, issue_rs, clear_fifos,
           active_rca, cfg_req, cfg_rca, wb_id, wb_fb, inflight, dbg_state
  );

  modport slave (
    input  req_valid, req_id, req_rca, req_fb, req_rs, cfg_done, flush, wb_commit,
    output req_ready, issue_valid, issue_id, issue_rca, issue_fb, issue_rs, clear_fifos,
           active_rca, cfg_req, cfg_rca, wb_id, wb_fb, inflight, dbg_state
  );
endinterface

// File: rtl/rca_issue_ctrl.sv
// RCA grid issue controller: one-entry request buffer, in-order writeback tracker,
// drain-then-reconfigure sequencing when a request targets a different accelerator.
module rca_issue_ctrl #(
  parameter int XLEN         = 32,
  parameter int NUM_PORTS    = 5,
  parameter int NUM_RCAS     = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int ID_W         = 3
) (
  input logic              clk,
  input logic              rst,
  rca_issue_ctrl_if.slave  bus
);
  localparam int RCA_W = (NUM_RCAS > 2) ? $clog2(NUM_RCAS) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int RS_W  = NUM_PORTS * XLEN;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

  localparam logic [1:0] ST_ACCEPT   = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_RECONFIG = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             buf_v_q, buf_v_d;
  logic [ID_W-1:0]  buf_id_q, buf_id_d;
  logic [RCA_W-1:0] buf_rca_q, buf_rca_d;
  logic             buf_fb_q, buf_fb_d;
  logic [RS_W-1:0]  buf_rs_q, buf_rs_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [RCA_W-1:0] active_rca_q, active_rca_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  trk_id_q [MAX_INFLIGHT];
  logic [ID_W-1:0]  trk_id_d [MAX_INFLIGHT];
  logic             trk_fb_q [MAX_INFLIGHT];
  logic             trk_fb_d [MAX_INFLIGHT];

  logic match, req_match, full, empty, issue, pop, ready, accept;

  always_comb begin
    match     = cfg_valid_q && (buf_rca_q == active_rca_q);
    // active_rca/cfg_valid cannot change while in ACCEPT, so a new request is judged against them directly
    req_match = cfg_valid_q && (bus.req_rca == active_rca_q);
    full      = (cnt_q == CNT_FULL);
    empty     = (cnt_q == '0);
    issue     = rst && !bus.flush && (state_q == ST_ACCEPT) && buf_v_q && match && !full;
    pop       = rst && !bus.flush && bus.wb_commit && !empty;
    ready     = rst && (state_q == ST_ACCEPT) && (!buf_v_q || issue) && !bus.flush;
    accept    = bus.req_valid && ready;
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    trk_id_d = trk_id_q;
    trk_fb_d = trk_fb_q;
    if (issue) begin
      trk_id_d[wr_ptr_q] = buf_id_q;
      trk_fb_d[wr_ptr_q] = buf_fb_q;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (bus.flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_v_d      = buf_v_q;
    buf_id_d     = buf_id_q;
    buf_rca_d    = buf_rca_q;
    buf_fb_d     = buf_fb_q;
    buf_rs_d     = buf_rs_q;
    cfg_valid_d  = cfg_valid_q;
    active_rca_d = active_rca_q;

    if (issue) buf_v_d = 1'b0;
    if (accept) begin
      buf_v_d   = 1'b1;
      buf_id_d  = bus.req_id;
      buf_rca_d = bus.req_rca;
      buf_fb_d  = bus.req_fb;
      buf_rs_d  = bus.req_rs;
    end

    case (state_q)
      ST_ACCEPT: begin
        if (accept && !req_match)
          state_d = (cnt_d != '0) ? ST_DRAIN : ST_RECONFIG;
        else if (buf_v_q && !match)
          state_d = (cnt_q != '0) ? ST_DRAIN : ST_RECONFIG;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_RECONFIG;
      end
      ST_RECONFIG: begin
        if (bus.cfg_done) begin
          active_rca_d = buf_rca_q;
          cfg_valid_d  = 1'b1;
          state_d      = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    // A flush mid-reconfiguration leaves the grid contents unknown
    if (bus.flush) begin
      state_d      = ST_ACCEPT;
      buf_v_d      = 1'b0;
      active_rca_d = active_rca_q;
      cfg_valid_d  = (state_q == ST_RECONFIG) ? 1'b0 : cfg_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_ACCEPT;
      buf_v_q      <= 1'b0;
      buf_id_q     <= '0;
      buf_rca_q    <= '0;
      buf_fb_q     <= 1'b0;
      buf_rs_q     <= '0;
      cfg_valid_q  <= 1'b0;
      active_rca_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      buf_v_q      <= buf_v_d;
      buf_id_q     <= buf_id_d;
      buf_rca_q    <= buf_rca_d;
      buf_fb_q     <= buf_fb_d;
      buf_rs_q     <= buf_rs_d;
      cfg_valid_q  <= cfg_valid_d;
      active_rca_q <= active_rca_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Tracker storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    trk_id_q <= trk_id_d;
    trk_fb_q <= trk_fb_d;
  end

  assign bus.req_ready   = ready;
  assign bus.issue_valid = issue;
  assign bus.issue_id    = buf_id_q;
  assign bus.issue_rca   = buf_rca_q;
  assign bus.issue_fb    = buf_fb_q;
  assign bus.issue_rs    = buf_rs_q;
  assign bus.clear_fifos = issue && empty;
  assign bus.active_rca  = active_rca_q;
  assign bus.cfg_req     = rst && (state_q == ST_RECONFIG);
  assign bus.cfg_rca     = buf_rca_q;
  assign bus.wb_id       = trk_id_q[rd_ptr_q];
  assign bus.wb_fb       = trk_fb_q[rd_ptr_q];
  assign bus.inflight    = cnt_q;
  assign bus.dbg_state   = state_q;
endmodule
